// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 16-bit CPU: data width, register count,
// instruction field positions, opcode and ALU op encodings, the control-unit
// state type and small decode/sign-extension helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int NREGS  = 8;

    // Instruction field bit positions
    localparam int OP_MSB    = 15;
    localparam int OP_LSB    = 12;
    localparam int RD_MSB    = 11;
    localparam int RD_LSB    = 9;
    localparam int RS1_MSB   = 8;
    localparam int RS1_LSB   = 6;
    localparam int RS2_MSB   = 5;
    localparam int RS2_LSB   = 3;
    localparam int IMM6_MSB  = 5;
    localparam int IMM9_MSB  = 8;
    localparam int IMM12_MSB = 11;

    // Opcodes
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_LI   = 4'h8;
    localparam logic [3:0] OP_ADDI = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    // ALU op encodings shared with the ALU
    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;

    typedef enum logic [2:0] {
        CU_IDLE,
        CU_FETCH,
        CU_DECODE,
        CU_EXECUTE,
        CU_HALT
    } cu_state_t;

    function automatic logic [DATA_W-1:0] sext6(input logic [IMM6_MSB:0] v);
        return {{(DATA_W-IMM6_MSB-1){v[IMM6_MSB]}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] sext9(input logic [IMM9_MSB:0] v);
        return {{(DATA_W-IMM9_MSB-1){v[IMM9_MSB]}}, v};
    endfunction

    // Opcodes 0x0-0x7 are register-register ALU operations
    function automatic logic is_rtype(input logic [3:0] op);
        return (op[3] == 1'b0);
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return (op == 4'hA) || (op == 4'hB) || (op == 4'hD) || (op == 4'hE);
    endfunction

endpackage

// File: rtl/module_control_unit_if.sv
// -----------------------------------------------------------------------------
// module_control_unit_if
// Bundles the instruction-fetch port and the ALU operand/result port of the
// control unit.
//   instr_req/instr_addr    : fetch request and address (control unit drives)
//   instr_valid/instr_data  : fetch response (memory drives)
//   alu_op/alu_in1/alu_in2  : registered ALU operation (control unit drives)
//   alu_result              : combinational ALU result (ALU drives)
// Modports: master = control unit, slave = memory/ALU side.
// -----------------------------------------------------------------------------
interface module_control_unit_if
    import cpu_pkg::*;
#(
    parameter int PC_W = 8
);
    logic              instr_req;
    logic [PC_W-1:0]   instr_addr;
    logic              instr_valid;
    logic [DATA_W-1:0] instr_data;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] alu_in1;
    logic [DATA_W-1:0] alu_in2;
    logic [DATA_W-1:0] alu_result;

    modport master (
        output instr_req, instr_addr, alu_op, alu_in1, alu_in2,
        input  instr_valid, instr_data, alu_result
    );

    modport slave (
        input  instr_req, instr_addr, alu_op, alu_in1, alu_in2,
        output instr_valid, instr_data, alu_result
    );
endinterface

// File: rtl/module_regfile.sv
// -----------------------------------------------------------------------------
// module_regfile
// 8 x 16 general-purpose register file (R0 is an ordinary register).
//   clk, rst_n             : clock, asynchronous active-low reset (clears all)
//   i_we/i_waddr/i_wdata   : single write port, lands on the rising edge
//   i_raddr1/o_rdata1      : combinational read port 1
//   i_raddr2/o_rdata2      : combinational read port 2
//   i_dbg_sel/o_dbg_data   : combinational debug read port
// -----------------------------------------------------------------------------
module module_regfile
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [2:0]        i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [2:0]        i_raddr1,
    output logic [DATA_W-1:0] o_rdata1,
    input  logic [2:0]        i_raddr2,
    output logic [DATA_W-1:0] o_rdata2,
    input  logic [2:0]        i_dbg_sel,
    output logic [DATA_W-1:0] o_dbg_data
);

    logic [DATA_W-1:0] r_regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Reads see the pre-write value in the write cycle, so rd == rs reads old data
    assign o_rdata1   = r_regs[i_raddr1];
    assign o_rdata2   = r_regs[i_raddr2];
    assign o_dbg_data = r_regs[i_dbg_sel];

endmodule

// File: rtl/module_control_unit.sv
// -----------------------------------------------------------------------------
// module_control_unit
// Multi-cycle fetch/decode/execute controller for the 16-bit CPU.
//   clk           : clock, rising edge
//   rst_n         : asynchronous active-low reset (release synchronised here)
//   run           : start request, leaves IDLE when high
//   bus (master)  : fetch port (instr_req/addr/valid/data) and
//                   ALU port (alu_op/in1/in2 out, alu_result in)
//   halted        : high in HALT
//   illegal_instr : one-cycle pulse after decoding an undefined opcode
//   dbg_sel       : debug register select
//   dbg_data      : combinational read of R[dbg_sel]
// -----------------------------------------------------------------------------
module module_control_unit
    import cpu_pkg::*;
#(
    parameter int PC_W = 8
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    module_control_unit_if.master bus,
    output logic                  halted,
    output logic                  illegal_instr,
    input  logic [2:0]            dbg_sel,
    output logic [DATA_W-1:0]     dbg_data
);

    // Reset asserts immediately, releases two clock edges later
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    cu_state_t         r_state;
    cu_state_t         w_state_next;
    logic [PC_W-1:0]   r_pc;
    logic [DATA_W-1:0] r_ir;
    logic [3:0]        r_alu_op;
    logic [DATA_W-1:0] r_alu_in1;
    logic [DATA_W-1:0] r_alu_in2;
    logic              r_illegal;

    logic [3:0]        w_op;
    logic [2:0]        w_rd;
    logic [2:0]        w_rs1;
    logic [2:0]        w_rs2;
    logic [DATA_W-1:0] w_rdata1;
    logic [DATA_W-1:0] w_rdata2;
    logic              w_rf_we;
    logic [DATA_W-1:0] w_rf_wdata;
    logic [PC_W-1:0]   w_jmp_target;

    assign w_op  = r_ir[OP_MSB:OP_LSB];
    assign w_rd  = r_ir[RD_MSB:RD_LSB];
    assign w_rs1 = r_ir[RS1_MSB:RS1_LSB];
    assign w_rs2 = r_ir[RS2_MSB:RS2_LSB];

    // JMP target is imm12 truncated to the PC width
    assign w_jmp_target = PC_W'(r_ir[IMM12_MSB:0]);

    module_regfile u_regfile (
        .clk        (clk),
        .rst_n      (w_rst_n),
        .i_we       (w_rf_we),
        .i_waddr    (w_rd),
        .i_wdata    (w_rf_wdata),
        .i_raddr1   (w_rs1),
        .o_rdata1   (w_rdata1),
        .i_raddr2   (w_rs2),
        .o_rdata2   (w_rdata2),
        .i_dbg_sel  (dbg_sel),
        .o_dbg_data (dbg_data)
    );

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= CU_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and register-file write control
    always_comb begin
        w_state_next = r_state;
        w_rf_we      = 1'b0;
        w_rf_wdata   = '0;
        unique case (r_state)
            CU_IDLE: begin
                if (run) begin
                    w_state_next = CU_FETCH;
                end
            end
            CU_FETCH: begin
                if (bus.instr_valid) begin
                    w_state_next = CU_DECODE;
                end
            end
            CU_DECODE: begin
                if (w_op == OP_HALT) begin
                    w_state_next = CU_HALT;
                end else if (is_rtype(w_op) || (w_op == OP_ADDI)) begin
                    w_state_next = CU_EXECUTE;
                end else begin
                    w_state_next = CU_FETCH;
                end
                if (w_op == OP_LI) begin
                    w_rf_we    = 1'b1;
                    w_rf_wdata = sext9(r_ir[IMM9_MSB:0]);
                end
            end
            CU_EXECUTE: begin
                w_rf_we      = 1'b1;
                w_rf_wdata   = bus.alu_result;
                w_state_next = CU_FETCH;
            end
            CU_HALT: begin
                w_state_next = CU_HALT;
            end
            default: begin
                w_state_next = CU_IDLE;
            end
        endcase
    end

    // PC, instruction register, ALU operand registers, illegal pulse
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_pc      <= '0;
            r_ir      <= '0;
            r_alu_op  <= '0;
            r_alu_in1 <= '0;
            r_alu_in2 <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= 1'b0;
            unique case (r_state)
                CU_FETCH: begin
                    if (bus.instr_valid) begin
                        r_ir <= bus.instr_data;
                        r_pc <= r_pc + 1'b1;
                    end
                end
                CU_DECODE: begin
                    if (is_rtype(w_op)) begin
                        r_alu_op  <= w_op;
                        r_alu_in1 <= w_rdata1;
                        r_alu_in2 <= w_rdata2;
                    end else if (w_op == OP_ADDI) begin
                        r_alu_op  <= ALU_ADD;
                        r_alu_in1 <= w_rdata1;
                        r_alu_in2 <= sext6(r_ir[IMM6_MSB:0]);
                    end else if (w_op == OP_JMP) begin
                        r_pc <= w_jmp_target;
                    end else if (is_illegal(w_op)) begin
                        r_illegal <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.instr_req  = (r_state == CU_FETCH);
    assign bus.instr_addr = r_pc;
    assign bus.alu_op     = r_alu_op;
    assign bus.alu_in1    = r_alu_in1;
    assign bus.alu_in2    = r_alu_in2;
    assign halted         = (r_state == CU_HALT);
    assign illegal_instr  = r_illegal;

endmodule

// File: tb/tb_module_control_unit.sv
// -----------------------------------------------------------------------------
// tb_module_control_unit
// Bench for module_control_unit: a memory model with configurable wait
// states, a combinational ALU model, directed programs, and a monitor that
// compares fetch addresses and ALU operands against expected queues.
// -----------------------------------------------------------------------------
module tb_module_control_unit;
    import cpu_pkg::*;

    localparam int PC_W = 8;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
    } alu_exp_t;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        halted;
    logic        illegal_instr;
    logic [2:0]  dbg_sel;
    logic [15:0] dbg_data;

    logic [15:0] mem [256];
    int          wait_states;
    int          wcnt;

    int checks;
    int errors;
    int ill_pulses;
    int cyc;

    logic [PC_W-1:0] q_addr [$];
    alu_exp_t        q_alu  [$];

    // monitor state
    int              alu_cd;
    int              ill_cd;
    logic            prev_req;
    logic            prev_valid;
    logic [PC_W-1:0] prev_addr;
    logic [3:0]      mon_op;
    alu_exp_t        mon_e;
    logic [PC_W-1:0] mon_a;

    module_control_unit_if #(.PC_W(PC_W)) bus ();

    module_control_unit #(.PC_W(PC_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .bus           (bus),
        .halted        (halted),
        .illegal_instr (illegal_instr),
        .dbg_sel       (dbg_sel),
        .dbg_data      (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model
    always_comb begin
        case (bus.alu_op)
            4'h0:    bus.alu_result = bus.alu_in1 + bus.alu_in2;
            4'h1:    bus.alu_result = bus.alu_in1 - bus.alu_in2;
            default: bus.alu_result = bus.alu_in1;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Memory model: responds after wait_states cycles of an active request
    initial begin
        bus.instr_valid = 1'b0;
        bus.instr_data  = '0;
        wcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.instr_req) begin
                if (wcnt < wait_states) begin
                    wcnt++;
                    bus.instr_valid = 1'b0;
                end else begin
                    wcnt = 0;
                    bus.instr_valid = 1'b1;
                    bus.instr_data  = mem[bus.instr_addr];
                end
            end else begin
                wcnt = 0;
                bus.instr_valid = 1'b0;
            end
        end
    end

    // Monitor: fetch addresses, address hold during waits, ALU operands in EXECUTE
    initial begin
        alu_cd = 0; ill_cd = 0; prev_req = 1'b0; prev_valid = 1'b0; prev_addr = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                alu_cd = 0; ill_cd = 0; prev_req = 1'b0; prev_valid = 1'b0;
            end else begin
                if (alu_cd != 0) begin
                    alu_cd--;
                    if (alu_cd == 0) begin
                        if (q_alu.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL alu_unexpected actual op=%0h required none", bus.alu_op);
                        end else begin
                            mon_e = q_alu.pop_front();
                            check("alu_op",  32'(bus.alu_op),  32'(mon_e.op));
                            check("alu_in1", 32'(bus.alu_in1), 32'(mon_e.a));
                            check("alu_in2", 32'(bus.alu_in2), 32'(mon_e.b));
                        end
                    end
                end
                if (ill_cd != 0) begin
                    ill_cd--;
                    if (ill_cd == 0) check("illegal_pulse", 32'(illegal_instr), 32'd1);
                end
                if (illegal_instr) ill_pulses++;
                if (bus.instr_req && prev_req && !prev_valid)
                    check("fetch_addr_hold", 32'(bus.instr_addr), 32'(prev_addr));
                if (bus.instr_req && bus.instr_valid) begin
                    if (q_addr.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL fetch_unexpected actual=%0h required none", bus.instr_addr);
                    end else begin
                        mon_a = q_addr.pop_front();
                        check("fetch_addr", 32'(bus.instr_addr), 32'(mon_a));
                    end
                    mon_op = bus.instr_data[15:12];
                    if (mon_op[3] == 1'b0 || mon_op == 4'h9) alu_cd = 2;
                    if (mon_op == 4'hA || mon_op == 4'hB || mon_op == 4'hD || mon_op == 4'hE) ill_cd = 2;
                end
                prev_req   = bus.instr_req;
                prev_valid = bus.instr_valid;
                prev_addr  = bus.instr_addr;
            end
        end
    end

    task automatic push_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        alu_exp_t e;
        e.op = op; e.a = a; e.b = b;
        q_alu.push_back(e);
    endtask

    task automatic push_addrs(input int first, input int n);
        for (int i = 0; i < n; i++) q_addr.push_back(PC_W'(first + i));
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run = 1'b0;
        wait_states = 0;
        repeat (2) @(negedge clk);
        q_addr.delete();
        q_alu.delete();
        ill_pulses = 0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Call at a falling edge; returns cycles from leaving IDLE to reaching HALT
    task automatic run_prog(input int max_cyc, output int cycles);
        int n;
        n = 0;
        run = 1'b1;
        while (n < max_cyc) begin
            @(posedge clk);
            #1;
            n++;
            if (halted) break;
        end
        run = 1'b0;
        cycles = n - 1;
        if (!halted) begin
            checks++; errors++;
            $display("FAIL halt_timeout actual=not_halted required=halted after %0d cycles", max_cyc);
        end
    endtask

    task automatic check_reg(input int idx, input logic [15:0] exp);
        dbg_sel = 3'(idx);
        #1;
        check($sformatf("R%0d", idx), 32'(dbg_data), 32'(exp));
    endtask

    task automatic check_queues_empty();
        check("addr_queue_left", 32'(q_addr.size()), 32'd0);
        check("alu_queue_left",  32'(q_alu.size()),  32'd0);
    endtask

    task automatic load_basic();
        clear_mem();
        mem[0] = 16'h8205;  // LI R1,5
        mem[1] = 16'h8403;  // LI R2,3
        mem[2] = 16'h0650;  // ADD R3,R1,R2
        mem[3] = 16'hF000;  // HALT
        push_addrs(0, 4);
        push_alu(4'h0, 16'd5, 16'd3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; ill_pulses = 0;
        rst_n = 1'b0; run = 1'b0; dbg_sel = '0; wait_states = 0;
        clear_mem();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_instr_req",  32'(bus.instr_req),  32'd0);
        check("rst_instr_addr", 32'(bus.instr_addr), 32'd0);
        check("rst_alu_op",     32'(bus.alu_op),     32'd0);
        check("rst_alu_in1",    32'(bus.alu_in1),    32'd0);
        check("rst_alu_in2",    32'(bus.alu_in2),    32'd0);
        check("rst_halted",     32'(halted),         32'd0);
        check("rst_illegal",    32'(illegal_instr),  32'd0);
        check_reg(0, 16'h0000);
        check_reg(7, 16'h0000);

        // Basic program, zero-wait
        do_reset();
        load_basic();
        run_prog(100, cyc);
        check("basic_cycles", 32'(cyc), 32'd9);
        check("basic_halted", 32'(halted), 32'd1);
        check_reg(1, 16'd5);
        check_reg(2, 16'd3);
        check_reg(3, 16'd8);
        check_queues_empty();

        // SUB, ADDI with sign extension, rd == rs operand read-before-write
        do_reset();
        clear_mem();
        mem[0] = 16'h8205;  // LI R1,5
        mem[1] = 16'h8403;  // LI R2,3
        mem[2] = 16'h1888;  // SUB R4,R2,R1
        mem[3] = 16'h9A3F;  // ADDI R5,R0,0x3F
        mem[4] = 16'h0248;  // ADD R1,R1,R1
        mem[5] = 16'hF000;  // HALT
        push_addrs(0, 6);
        push_alu(4'h1, 16'd3, 16'd5);
        push_alu(4'h0, 16'd0, 16'hFFFF);
        push_alu(4'h0, 16'd5, 16'd5);
        run_prog(100, cyc);
        check("subaddi_cycles", 32'(cyc), 32'd15);
        check_reg(4, 16'hFFFE);
        check_reg(5, 16'hFFFF);
        check_reg(1, 16'h000A);
        check_queues_empty();

        // Basic program with three wait states per fetch
        do_reset();
        load_basic();
        wait_states = 3;
        run_prog(200, cyc);
        check("wait_cycles", 32'(cyc), 32'd21);
        check_reg(3, 16'd8);
        check_queues_empty();

        // PC wrap: JMP 0xFFE truncates to 0xFE, 0xFF + 1 wraps to 0x00
        do_reset();
        clear_mem();
        mem[0]    = 16'hCFFE;  // JMP 0xFFE
        mem[8'hFE] = 16'h8201; // LI R1,1
        mem[8'hFF] = 16'h8402; // LI R2,2
        q_addr.push_back(8'h00);
        q_addr.push_back(8'hFE);
        q_addr.push_back(8'hFF);
        q_addr.push_back(8'h00);
        fork
            run_prog(100, cyc);
            begin
                repeat (3) @(negedge clk);
                mem[0] = 16'hF000;  // second visit to 0x00 halts
            end
        join
        check("wrap_cycles", 32'(cyc), 32'd8);
        check_reg(1, 16'd1);
        check_reg(2, 16'd2);
        check_queues_empty();

        // Illegal opcode, then LI with negative imm9
        do_reset();
        clear_mem();
        mem[0] = 16'h8205;  // LI R1,5
        mem[1] = 16'hB000;  // illegal
        mem[2] = 16'h8D00;  // LI R6,0x100 -> 0xFF00
        mem[3] = 16'hF000;  // HALT
        push_addrs(0, 4);
        run_prog(100, cyc);
        check("illegal_cycles", 32'(cyc), 32'd8);
        check("illegal_pulse_count", 32'(ill_pulses), 32'd1);
        check_reg(0, 16'h0000);
        check_reg(1, 16'd5);
        check_reg(6, 16'hFF00);
        check_queues_empty();

        // Reset asserted during SUB's EXECUTE
        do_reset();
        clear_mem();
        mem[0] = 16'h8205;  // LI R1,5
        mem[1] = 16'h8403;  // LI R2,3
        mem[2] = 16'h1888;  // SUB R4,R2,R1
        mem[3] = 16'hF000;  // HALT
        push_addrs(0, 3);
        push_alu(4'h1, 16'd3, 16'd5);
        run = 1'b1;
        repeat (7) @(posedge clk);
        #7;
        rst_n = 1'b0;
        run = 1'b0;
        #1;
        check("midrst_instr_req",  32'(bus.instr_req),  32'd0);
        check("midrst_instr_addr", 32'(bus.instr_addr), 32'd0);
        check("midrst_alu_op",     32'(bus.alu_op),     32'd0);
        check("midrst_alu_in1",    32'(bus.alu_in1),    32'd0);
        check("midrst_alu_in2",    32'(bus.alu_in2),    32'd0);
        check("midrst_halted",     32'(halted),         32'd0);
        check("midrst_illegal",    32'(illegal_instr),  32'd0);
        check_queues_empty();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_no_req", 32'(bus.instr_req), 32'd0);
        end
        check_reg(4, 16'h0000);
        check_reg(1, 16'h0000);
        @(negedge clk);
        push_addrs(0, 4);
        push_alu(4'h1, 16'd3, 16'd5);
        run_prog(100, cyc);
        check("restart_cycles", 32'(cyc), 32'd9);
        check_reg(4, 16'hFFFE);
        check_queues_empty();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
